// File: rtl/rgb_pwm_pkg.sv
// Shared types and constants for the RGB PWM driver.
package rgb_pwm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    FADING  = 2'd2
  } state_e;

  localparam int   DUTY_W  = 8;
  localparam logic LED_OFF = 1'b1;

  // One fade step toward target; the 9-bit sum keeps 255+step from wrapping.
  function automatic logic [DUTY_W-1:0] fadeToward(input logic [DUTY_W-1:0] cur,
                                                   input logic [DUTY_W-1:0] target,
                                                   input logic [DUTY_W-1:0] step);
    logic [DUTY_W:0] sum;
    sum = {1'b0, cur} + {1'b0, step};
    if (cur < target)
      fadeToward = (sum >= {1'b0, target}) ? target : sum[DUTY_W-1:0];
    else
      fadeToward = ((cur - target) <= step) ? target : cur - step;
  endfunction

endpackage

// File: rtl/rgb_pwm_if.sv
// Colour handshake between a colour producer (master) and the PWM driver (slave).
interface rgb_pwm_if;
  import rgb_pwm_pkg::*;

  logic              color_valid;
  logic              color_ready;
  logic [DUTY_W-1:0] color_r;
  logic [DUTY_W-1:0] color_g;
  logic [DUTY_W-1:0] color_b;

  modport master (output color_valid, color_r, color_g, color_b, input color_ready);
  modport slave  (input color_valid, color_r, color_g, color_b, output color_ready);

endinterface

// File: rtl/rgb_pwm_channel.sv
// One PWM colour channel: duty register, optional fade toward a target, registered pin.
// Fade logic is present only when RGB_PWM_FADE_EN is defined.
module rgb_pwm_channel
  import rgb_pwm_pkg::*;
`ifdef RGB_PWM_FADE_EN
#(
  parameter int FADE_STEP = 4
)
`endif
(
  input  logic              clk48,
  input  logic              rst_n,
  input  logic [DUTY_W-1:0] pwmCnt_i,
  input  logic              periodStart_i,
  input  logic              load_i,
  input  logic [DUTY_W-1:0] loadVal_i,
`ifdef RGB_PWM_FADE_EN
  output logic              atTarget_o,
`endif
  output logic              pin_o
);

  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              pin_q;

`ifdef RGB_PWM_FADE_EN
  logic [DUTY_W-1:0] target_q, target_d;

  // atTarget_o reports the post-step duty, so the FSM can leave on the final step.
  always_comb begin
    target_d = target_q;
    duty_d   = duty_q;
    if (periodStart_i) begin
      if (load_i) target_d = loadVal_i;
      duty_d = fadeToward(duty_q, target_d, DUTY_W'(FADE_STEP));
    end
  end

  assign atTarget_o = (duty_d == target_d);

  always_ff @(posedge clk48) begin
    if (!rst_n) target_q <= '0;
    else        target_q <= target_d;
  end
`else
  always_comb begin
    duty_d = duty_q;
    if (periodStart_i && load_i) duty_d = loadVal_i;
  end
`endif

  always_ff @(posedge clk48) begin
    if (!rst_n) begin
      duty_q <= '0;
      pin_q  <= LED_OFF;
    end else begin
      duty_q <= duty_d;
      pin_q  <= ~(pwmCnt_i < duty_q);
    end
  end

  assign pin_o = pin_q;

endmodule

// File: rtl/rgb_pwm_driver.sv
// Active-low RGB LED PWM driver; colours are accepted by handshake and applied on period wrap.
// Define RGB_PWM_FADE_EN to fade each channel toward the new colour by FADE_STEP per period.
module rgb_pwm_driver
  import rgb_pwm_pkg::*;
#(
  parameter int PRESCALE = 188
`ifdef RGB_PWM_FADE_EN
  , parameter int FADE_STEP = 4
`endif
) (
  input  logic       clk48,
  input  logic       rst_n,
  rgb_pwm_if.slave   color,
  output logic       period_start_o,
  output logic       busy_o,
  output logic       rgb_led0_r_o,
  output logic       rgb_led0_g_o,
  output logic       rgb_led0_b_o
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PRE_W-1:0]         preCnt_q, preCnt_d;
  logic [DUTY_W-1:0]        pwmCnt_q, pwmCnt_d;
  logic                     periodStart_q;
  logic                     tick, wrap, transfer, loadCh;
  state_e                   state_q, state_d;
  logic [2:0][DUTY_W-1:0]   pend_q, pend_d;
  logic [2:0]               pins;
`ifdef RGB_PWM_FADE_EN
  logic [2:0]               atTarget;
`endif

  // wrap marks the edge where pwmCnt goes 255->0; duties load on that same edge.
  assign tick     = (preCnt_q == PRE_W'(PRESCALE - 1));
  assign wrap     = tick && (pwmCnt_q == '1);
  assign transfer = color.color_valid && color.color_ready;

  always_comb begin
    preCnt_d = tick ? '0 : preCnt_q + 1'b1;
    pwmCnt_d = tick ? pwmCnt_q + 1'b1 : pwmCnt_q;
    pend_d   = pend_q;
    if (transfer) pend_d = {color.color_b, color.color_g, color.color_r};
  end

  always_ff @(posedge clk48) begin
    if (!rst_n) begin
      preCnt_q      <= '0;
      pwmCnt_q      <= '0;
      periodStart_q <= 1'b0;
      pend_q        <= '0;
      state_q       <= IDLE;
    end else begin
      preCnt_q      <= preCnt_d;
      pwmCnt_q      <= pwmCnt_d;
      periodStart_q <= wrap;
      pend_q        <= pend_d;
      state_q       <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (transfer) state_d = PENDING;
`ifdef RGB_PWM_FADE_EN
      PENDING: if (wrap) state_d = (&atTarget) ? IDLE : FADING;
      FADING:  if (wrap && (&atTarget)) state_d = IDLE;
`else
      PENDING: if (wrap) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    color.color_ready = (state_q == IDLE);
    busy_o            = (state_q != IDLE);
    loadCh            = (state_q == PENDING);
  end

  for (genvar i = 0; i < 3; i++) begin : g_ch
`ifdef RGB_PWM_FADE_EN
    rgb_pwm_channel #(.FADE_STEP(FADE_STEP)) u_ch (
      .clk48        (clk48),
      .rst_n        (rst_n),
      .pwmCnt_i     (pwmCnt_q),
      .periodStart_i(wrap),
      .load_i       (loadCh),
      .loadVal_i    (pend_q[i]),
      .atTarget_o   (atTarget[i]),
      .pin_o        (pins[i])
    );
`else
    rgb_pwm_channel u_ch (
      .clk48        (clk48),
      .rst_n        (rst_n),
      .pwmCnt_i     (pwmCnt_q),
      .periodStart_i(wrap),
      .load_i       (loadCh),
      .loadVal_i    (pend_q[i]),
      .pin_o        (pins[i])
    );
`endif
  end

  assign period_start_o = periodStart_q;
  assign rgb_led0_r_o   = pins[0];
  assign rgb_led0_g_o   = pins[1];
  assign rgb_led0_b_o   = pins[2];

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Randomised and directed bench for rgb_pwm_driver against a cycle-count reference model.
// Fade checks are included when RGB_PWM_FADE_EN is defined.
module tb_rgb_pwm_driver;

  localparam int P      = 2;
  localparam int STEP   = 16;
  localparam int PERIOD = 256 * P;

  logic clk48 = 1'b0;
  logic rstN  = 1'b0;
  logic periodStartO, busyO, ledR, ledG, ledB;

  rgb_pwm_if colorIf ();

`ifdef RGB_PWM_FADE_EN
  rgb_pwm_driver #(.PRESCALE(P), .FADE_STEP(STEP)) dut (
`else
  rgb_pwm_driver #(.PRESCALE(P)) dut (
`endif
    .clk48         (clk48),
    .rst_n         (rstN),
    .color         (colorIf.slave),
    .period_start_o(periodStartO),
    .busy_o        (busyO),
    .rgb_led0_r_o  (ledR),
    .rgb_led0_g_o  (ledG),
    .rgb_led0_b_o  (ledB)
  );

  always #5 clk48 = ~clk48;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: cycles since reset, duties as integers, pending/fade flags.
  int n;
  int duty[3], tgt[3], pend[3];
  bit pendF, fadeF, busyM, psM;
  bit pinM[3];

  function automatic int toward(int cur, int target, int step);
    if (cur < target) return (cur + step > target) ? target : cur + step;
    return (cur - step < target) ? target : cur - step;
  endfunction

  task automatic modelStep();
    int  prevPwm;
    int  prevDuty[3];
    bit  wrapNow, captured, allEq;
    if (!rstN) begin
      n = 0; pendF = 0; fadeF = 0; busyM = 0; psM = 0;
      for (int i = 0; i < 3; i++) begin
        duty[i] = 0; tgt[i] = 0; pend[i] = 0; pinM[i] = 1;
      end
      return;
    end
    prevPwm  = (n / P) % 256;
    prevDuty = duty;
    n++;
    wrapNow  = (n % PERIOD) == 0;
    captured = !busyM && colorIf.color_valid;
    if (wrapNow) begin
`ifdef RGB_PWM_FADE_EN
      if (pendF) begin
        tgt = pend; pendF = 0; fadeF = 1;
      end
      if (fadeF) begin
        allEq = 1;
        for (int i = 0; i < 3; i++) begin
          duty[i] = toward(duty[i], tgt[i], STEP);
          if (duty[i] != tgt[i]) allEq = 0;
        end
        if (allEq) fadeF = 0;
      end
`else
      if (pendF) begin
        duty = pend; pendF = 0;
      end
`endif
    end
    if (captured) begin
      pend[0] = int'(colorIf.color_r);
      pend[1] = int'(colorIf.color_g);
      pend[2] = int'(colorIf.color_b);
      pendF = 1;
    end
    busyM = pendF || fadeF;
    psM   = wrapNow;
    for (int i = 0; i < 3; i++) pinM[i] = !(prevPwm < prevDuty[i]);
  endtask

  task automatic checkOutput(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model with them, then compare all outputs.
  task automatic applyStimulus(input bit rst, input bit v, input logic [7:0] r,
                               input logic [7:0] g, input logic [7:0] b);
    rstN = rst;
    colorIf.color_valid = v;
    colorIf.color_r = r;
    colorIf.color_g = g;
    colorIf.color_b = b;
    @(posedge clk48);
    modelStep();
    #1;
    checkOutput("pinR", int'(ledR), int'(pinM[0]));
    checkOutput("pinG", int'(ledG), int'(pinM[1]));
    checkOutput("pinB", int'(ledB), int'(pinM[2]));
    checkOutput("ready", int'(colorIf.color_ready), int'(!busyM));
    checkOutput("busy", int'(busyO), int'(busyM));
    checkOutput("periodStart", int'(periodStartO), int'(psM));
  endtask

  task automatic idleCycles(input int cnt);
    for (int i = 0; i < cnt; i++) applyStimulus(1, 0, 8'd0, 8'd0, 8'd0);
  endtask

  task automatic waitPeriodStart();
    bit seen;
    seen = 0;
    for (int i = 0; i < PERIOD + 8 && !seen; i++) begin
      applyStimulus(1, 0, 8'd0, 8'd0, 8'd0);
      seen = periodStartO;
    end
    if (!seen) checkOutput("periodStartTimeout", 0, 1);
  endtask

  // Keep offering a colour only while the model says the driver is busy.
  task automatic holdWhileBusy(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    for (int i = 0; i < 2 * PERIOD && busyM; i++) applyStimulus(1, 1, r, g, b);
    if (busyM) checkOutput("busyTimeout", 1, 0);
  endtask

  function automatic logic [7:0] pickDuty();
    case ($urandom_range(0, 3))
      0:       return 8'd0;
      1:       return 8'd255;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    int litR, litG, litB;
    colorIf.color_valid = 0;
    colorIf.color_r = 0;
    colorIf.color_g = 0;
    colorIf.color_b = 0;

    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 8'd99, 8'd99, 8'd99);
    checkOutput("resetPinR", int'(ledR), 1);
    checkOutput("resetReady", int'(colorIf.color_ready), 1);

    applyStimulus(1, 1, 8'd128, 8'd0, 8'd255);
    waitPeriodStart();
    litR = 0; litG = 0; litB = 0;
    for (int i = 0; i < PERIOD; i++) begin
      applyStimulus(1, 0, 8'd0, 8'd0, 8'd0);
      litR += int'(!ledR); litG += int'(!ledG); litB += int'(!ledB);
    end
`ifndef RGB_PWM_FADE_EN
    checkOutput("litCyclesR", litR, 256);
    checkOutput("litCyclesG", litG, 0);
    checkOutput("litCyclesB", litB, 510);
`endif

    applyStimulus(1, 1, 8'd60, 8'd70, 8'd80);
    holdWhileBusy(8'd10, 8'd0, 8'd0);
    idleCycles(PERIOD + 4);

    waitPeriodStart();
    applyStimulus(1, 1, 8'd200, 8'd100, 8'd50);
    waitPeriodStart();
    waitPeriodStart();
    idleCycles(PERIOD);

`ifdef RGB_PWM_FADE_EN
    applyStimulus(0, 0, 8'd0, 8'd0, 8'd0);
    applyStimulus(1, 1, 8'd40, 8'd0, 8'd0);
    idleCycles(4 * PERIOD);
    applyStimulus(1, 1, 8'd0, 8'd0, 8'd0);
    idleCycles(4 * PERIOD);
    applyStimulus(1, 1, 8'd255, 8'd1, 8'd128);
    idleCycles(18 * PERIOD);
    applyStimulus(1, 1, 8'd200, 8'd0, 8'd0);
    waitPeriodStart();
    idleCycles(PERIOD / 2);
`else
    applyStimulus(1, 1, 8'd200, 8'd0, 8'd0);
    idleCycles(PERIOD / 4);
`endif
    applyStimulus(0, 0, 8'd0, 8'd0, 8'd0);
    checkOutput("midResetBusy", int'(busyO), 0);
    applyStimulus(1, 1, 8'd33, 8'd66, 8'd99);
    checkOutput("acceptAfterReset", int'(busyO), 1);
    idleCycles(2 * PERIOD);

    for (int i = 0; i < 12000; i++)
      applyStimulus($urandom_range(0, 4999) != 0, $urandom_range(0, 7) == 0,
                    pickDuty(), pickDuty(), pickDuty());

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
